// File: rtl/butterfly_ctrl.sv
// butterfly_ctrl: in-place 256-point NTT/INTT schedule over a
// dual-port coefficient RAM, twiddle ROM and pipelined butterfly.
module butterfly_ctrl #(
  parameter int BF_LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode_in,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [7:0]  rd_addr_a,
  output logic [7:0]  rd_addr_b,
  input  logic [31:0] rd_data_a,
  input  logic [31:0] rd_data_b,
  output logic [7:0]  tw_addr,
  input  logic [31:0] tw_data,
  output logic [31:0] bf_a,
  output logic [31:0] bf_b,
  output logic [31:0] bf_w,
  output logic [1:0]  bf_mode,
  input  logic [31:0] bf_c,
  input  logic [31:0] bf_d,
  output logic        wr_en,
  output logic [7:0]  wr_addr_a,
  output logic [7:0]  wr_addr_b,
  output logic [31:0] wr_data_a,
  output logic [31:0] wr_data_b
);

  localparam int DEP = BF_LAT + 1;
  localparam int CW  = $clog2(BF_LAT + 2);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  logic [2:0]    stg;
  logic [6:0]    idx;
  logic [CW-1:0] dcnt;
  logic          inv;

  logic [7:0] len;
  logic [7:0] grp;
  logic [7:0] ofs;
  logic [7:0] base;
  logic [7:0] addr;
  logic [7:0] tw;

  logic [DEP-1:0] dv;
  logic [7:0]     da [DEP];
  logic [7:0]     db [DEP];

  // Sequence stages: 128 issues, then drain the butterfly pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      stg   <= '0;
      idx   <= '0;
      dcnt  <= '0;
      inv   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rd_en <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !mode_in[1]) begin
            state <= RUN;
            inv   <= mode_in[0];
            stg   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            rd_en <= 1'b1;
          end
        end
        RUN: begin
          if (idx == 7'd127) begin
            state <= DRAIN;
            rd_en <= 1'b0;
            dcnt  <= '0;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        DRAIN: begin
          if (dcnt == CW'(BF_LAT)) begin
            if (stg == 3'd7) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              stg   <= stg + 3'd1;
              idx   <= '0;
              rd_en <= 1'b1;
            end
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Map issue index to pair addresses and twiddle index.
  always_comb begin
    if (inv) begin
      len  = 8'd1 << stg;
      grp  = {1'b0, idx} >> stg;
      base = grp << ({1'b0, stg} + 4'd1);
      tw   = ~(8'hff >> stg) + grp;
    end else begin
      len  = 8'd128 >> stg;
      grp  = {1'b0, idx} >> (3'd7 - stg);
      base = grp << (4'd8 - {1'b0, stg});
      tw   = (8'd1 << stg) + grp;
    end
    ofs  = {1'b0, idx} & (len - 8'd1);
    addr = base + ofs;
  end

  assign rd_addr_a = rd_en ? addr : '0;
  assign rd_addr_b = rd_en ? addr + len : '0;
  assign tw_addr   = rd_en ? tw : '0;

  // Carry write addresses alongside the read + butterfly latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv <= '0;
      for (int k = 0; k < DEP; k++) begin
        da[k] <= '0;
        db[k] <= '0;
      end
    end else begin
      dv[0] <= rd_en;
      da[0] <= rd_addr_a;
      db[0] <= rd_addr_b;
      for (int k = 1; k < DEP; k++) begin
        dv[k] <= dv[k-1];
        da[k] <= da[k-1];
        db[k] <= db[k-1];
      end
    end
  end

  assign bf_a    = dv[0] ? rd_data_a : '0;
  assign bf_b    = dv[0] ? rd_data_b : '0;
  assign bf_w    = dv[0] ? tw_data : '0;
  assign bf_mode = dv[0] ? {1'b0, inv} : 2'b11;

  assign wr_en     = dv[DEP-1];
  assign wr_addr_a = wr_en ? da[DEP-1] : '0;
  assign wr_addr_b = wr_en ? db[DEP-1] : '0;
  assign wr_data_a = wr_en ? bf_c : '0;
  assign wr_data_b = wr_en ? bf_d : '0;

endmodule

// File: tb/tb_butterfly_ctrl.sv
// tb_butterfly_ctrl: RAM/ROM/butterfly models around butterfly_ctrl,
// schedule scoreboard and software NTT reference.
module tb_butterfly_ctrl;

  localparam int BF_LAT = 7;
  localparam longint unsigned Q = 64'd8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode_in = 2'b00;
  logic        busy, done, rd_en, wr_en;
  logic [7:0]  rd_addr_a, rd_addr_b, tw_addr;
  logic [31:0] rd_data_a = '0;
  logic [31:0] rd_data_b = '0;
  logic [31:0] tw_data = '0;
  logic [31:0] bf_a, bf_b, bf_w, bf_c, bf_d;
  logic [1:0]  bf_mode;
  logic [7:0]  wr_addr_a, wr_addr_b;
  logic [31:0] wr_data_a, wr_data_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] ram [256];
  logic [31:0] ld_buf [256];
  logic        ld = 1'b0;
  logic        rom_intt = 1'b0;
  logic [31:0] zn [256];
  logic [31:0] zi [256];
  logic [63:0] pc [BF_LAT];

  longint unsigned gold [256];
  longint unsigned xin [256];

  logic [23:0] exp_q [$];
  int          wq_c [$];
  logic [15:0] wq_a [$];
  bit          prev_rd = 1'b0;
  logic        cur_mode = 1'b0;
  int          nwr = 0;
  int          ndone = 0;

  logic [205:0] ovec;
  assign ovec = {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                 bf_a, bf_b, bf_w, wr_en, wr_addr_a, wr_addr_b,
                 wr_data_a, wr_data_b, bf_mode};

  butterfly_ctrl #(.BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .tw_addr(tw_addr), .tw_data(tw_data),
    .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_mode(bf_mode),
    .bf_c(bf_c), .bf_d(bf_d), .wr_en(wr_en),
    .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bfly(logic [31:0] a, logic [31:0] b,
                                       logic [31:0] w, logic [1:0] m);
    longint unsigned la, lb, lw, t, c, d;
    la = {32'd0, a};
    lb = {32'd0, b};
    lw = {32'd0, w};
    c = 0;
    d = 0;
    if (m == 2'b00) begin
      t = (lb * lw) % Q;
      c = (la + t) % Q;
      d = (la + Q - t) % Q;
    end else if (m == 2'b01) begin
      c = (la + lb) % Q;
      d = (((la + Q - lb) % Q) * lw) % Q;
    end
    return {c[31:0], d[31:0]};
  endfunction

  assign bf_c = pc[BF_LAT-1][63:32];
  assign bf_d = pc[BF_LAT-1][31:0];

  // Registered RAM/ROM reads, RAM writes and the butterfly pipe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      rd_data_a <= ram[rd_addr_a];
      rd_data_b <= ram[rd_addr_b];
    end
    tw_data <= rom_intt ? zi[tw_addr] : zn[tw_addr];
    pc[0] <= bfly(bf_a, bf_b, bf_w, bf_mode);
    for (int k = 1; k < BF_LAT; k++) pc[k] <= pc[k-1];
    if (ld) begin
      for (int k = 0; k < 256; k++) ram[k] <= ld_buf[k];
    end else if (wr_en) begin
      ram[wr_addr_a] <= wr_data_a;
      ram[wr_addr_b] <= wr_data_b;
    end
  end

  function automatic longint unsigned pw(int e);
    longint unsigned r = 1;
    for (int n = 0; n < e; n++) r = (r * 64'd1753) % Q;
    return r;
  endfunction

  function automatic int brv8(int k);
    int r = 0;
    for (int b = 0; b < 8; b++)
      if (((k >> b) & 1) == 1) r = r | (1 << (7 - b));
    return r;
  endfunction

  function automatic void sw_ntt();
    int k = 0;
    longint unsigned z, t;
    for (int len = 128; len > 0; len = len / 2) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        k++;
        z = {32'd0, zn[k]};
        for (int j = st; j < st + len; j++) begin
          t = (z * gold[j+len]) % Q;
          gold[j+len] = (gold[j] + Q - t) % Q;
          gold[j] = (gold[j] + t) % Q;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_sched(input bit inv);
    int k;
    exp_q.delete();
    if (!inv) begin
      k = 0;
      for (int len = 128; len > 0; len = len / 2)
        for (int st = 0; st < 256; st += 2 * len) begin
          k++;
          for (int j = st; j < st + len; j++)
            exp_q.push_back({8'(j), 8'(j + len), 8'(k)});
        end
    end else begin
      k = 256;
      for (int len = 1; len <= 128; len = len * 2)
        for (int st = 0; st < 256; st += 2 * len) begin
          k--;
          for (int j = st; j < st + len; j++)
            exp_q.push_back({8'(j), 8'(j + len), 8'(255 - k)});
        end
    end
  endtask

  task automatic mon_step();
    logic [23:0] e;
    logic [15:0] a;
    int c;
    if (rd_en) begin
      if (exp_q.size() == 0) chk("issue_extra", rd_en, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("issue", {rd_addr_a, rd_addr_b, tw_addr}, e);
      end
      wq_c.push_back(cyc);
      wq_a.push_back({rd_addr_a, rd_addr_b});
    end
    chk("bf_mode", bf_mode, prev_rd ? {1'b0, cur_mode} : 2'b11);
    prev_rd = rd_en;
    if (wr_en) begin
      nwr++;
      if (wq_c.size() == 0) chk("wr_extra", wr_en, 1'b0);
      else begin
        c = wq_c.pop_front();
        a = wq_a.pop_front();
        chk("wr_lat", cyc - c, 1 + BF_LAT);
        chk("wr_addr", {wr_addr_a, wr_addr_b}, a);
      end
    end
    if (done) ndone++;
  endtask

  task automatic arm(input bit inv);
    build_sched(inv);
    rom_intt = inv;
    cur_mode = inv;
    wq_c.delete();
    wq_a.delete();
    prev_rd = 1'b0;
  endtask

  task automatic load_ram();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run_xform(input bit inv, input bit glitch);
    int t0, w0, d0;
    bit got;
    arm(inv);
    w0 = nwr;
    d0 = ndone;
    @(negedge clk);
    start = 1'b1;
    mode_in = {1'b0, inv};
    t0 = cyc;
    mon_step();
    @(negedge clk);
    start = 1'b0;
    mon_step();
    chk("busy_on", busy, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 1200 && !got; n++) begin
      @(negedge clk);
      if (glitch && n == 300) begin
        start = 1'b1;
        mode_in = {1'b0, ~inv};
      end else if (glitch && n == 700) begin
        start = 1'b1;
        mode_in = 2'b10;
      end else begin
        start = 1'b0;
      end
      mon_step();
      if (done) got = 1'b1;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", done, 1'b1);
    else begin
      chk("latency", cyc - t0, 1089);
      chk("busy_at_done", busy, 1'b0);
    end
    @(negedge clk);
    mon_step();
    chk("done_pulse", done, 1'b0);
    chk("ndone", ndone - d0, 1);
    chk("nwrites", nwr - w0, 1024);
    chk("sched_left", exp_q.size(), 0);
    chk("wq_left", wq_c.size(), 0);
  endtask

  function automatic int nbad_gold();
    int nb = 0;
    for (int k = 0; k < 256; k++)
      if (ram[k] !== gold[k][31:0]) nb++;
    return nb;
  endfunction

  task automatic rand_in();
    for (int k = 0; k < 256; k++) begin
      xin[k] = {32'd0, $urandom} % Q;
      gold[k] = xin[k];
      ld_buf[k] = xin[k][31:0];
    end
  endtask

  initial begin
    int t0;
    for (int k = 0; k < 256; k++) zn[k] = 32'(pw(brv8(k)));
    for (int k = 0; k < 256; k++)
      zi[k] = 32'((Q - {32'd0, zn[255-k]}) % Q);

    #1 rst = 1'b0;
    #1 chk("rst_outs", ovec, 206'd3);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", ovec, 206'd3);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("idle_hold", ovec, 206'd3);
    end

    @(negedge clk);
    start = 1'b1;
    mode_in = 2'b10;
    @(negedge clk);
    mode_in = 2'b11;
    @(negedge clk);
    start = 1'b0;
    mode_in = 2'b00;
    repeat (4) begin
      @(negedge clk);
      chk("bad_mode", ovec, 206'd3);
    end

    for (int k = 0; k < 256; k++) ld_buf[k] = (k == 0) ? 32'd1 : 32'd0;
    load_ram();
    run_xform(1'b0, 1'b1);
    for (int k = 0; k < 256; k++) gold[k] = 1;
    chk("ntt_delta", nbad_gold(), 0);

    rand_in();
    sw_ntt();
    load_ram();
    run_xform(1'b0, 1'b1);
    chk("ntt_rand", nbad_gold(), 0);
    run_xform(1'b1, 1'b1);
    for (int k = 0; k < 256; k++) gold[k] = (xin[k] * 256) % Q;
    chk("intt_round", nbad_gold(), 0);

    rand_in();
    load_ram();
    arm(1'b0);
    @(negedge clk);
    start = 1'b1;
    mode_in = 2'b00;
    t0 = cyc;
    mon_step();
    @(negedge clk);
    start = 1'b0;
    mon_step();
    for (int n = 0; n < 600 && cyc < t0 + 1 + 3 * 136 + 40; n++) begin
      @(negedge clk);
      mon_step();
    end
    @(posedge clk);
    #2;
    chk("pre_rst_wr", wr_en, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_wr", wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_all", ovec, 206'd3);
    @(negedge clk);
    rst = 1'b1;

    sw_ntt();
    load_ram();
    run_xform(1'b0, 1'b0);
    chk("ntt_after_rst", nbad_gold(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
